// File: rtl/usb_transaction_sequencer.sv
// Device-side USB low-speed transaction sequencer: token/data/handshake sequencing and per-endpoint data toggles.
// Optional build macro USB_SEQ_ERRCNT_EN adds a saturating err_count output.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | waiting for a token addressed to this device
// GET_DATA | OUT/SETUP accepted, waiting for the DATAx packet and its end
// TURN     | response decided, counting bus turnaround
// SEND     | tx_req held with tx_pid until tx_done
// WAIT_HS  | DATAx sent for IN, waiting for the host handshake
module usb_transaction_sequencer #(
    parameter int NUM_EP      = 4,
    parameter int TURN_CYC    = 48,
    parameter int TIMEOUT_CYC = 288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        dev_addr,
    input  logic              rx_active,
    input  logic              rx_error,
    input  logic [3:0]        pid,
    input  logic              pid_valid,
    input  logic [6:0]        address,
    input  logic [3:0]        end_point,
    input  logic              token_valid,
    input  logic              crc16_ok,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] ep_out_rdy,
    input  logic [NUM_EP-1:0] ep_in_rdy,
    output logic [3:0]        tx_pid,
    output logic              tx_req,
    input  logic              tx_done,
    output logic [3:0]        ep_sel,
    output logic              setup_seen,
    output logic              out_commit,
    output logic              out_discard,
    output logic              in_commit
`ifdef USB_SEQ_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam int MAX_CYC = (TIMEOUT_CYC > TURN_CYC) ? TIMEOUT_CYC : TURN_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYC - 1);
    localparam logic [TMR_W-1:0] TOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, GET_DATA, TURN, SEND, WAIT_HS} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       ep_q, ep_d;
    logic [3:0]       tok_q, tok_d;
    logic [3:0]       resp_q, resp_d;
    logic             data_seen_q, data_seen_d;
    logic             data1_q, data1_d;
    logic             err_seen_q, err_seen_d;
    logic             rx_active_q;
    logic [15:0]      toggle_q, toggle_d;
    logic             setup_seen_q, setup_seen_d;
    logic             out_commit_q, out_commit_d;
    logic             out_discard_q, out_discard_d;
    logic             in_commit_q, in_commit_d;
    logic             err_inc;

    // endpoint vectors widened so a 4-bit endpoint index is always in range
    logic [15:0] stall_v, out_rdy_v, in_rdy_v;
    logic        pid_ok, rx_fall, tmr_zero, tok_hit;

    assign stall_v   = 16'(ep_stall);
    assign out_rdy_v = 16'(ep_out_rdy);
    assign in_rdy_v  = 16'(ep_in_rdy);
    assign pid_ok    = pid_valid & ~rx_error;
    assign rx_fall   = rx_active_q & ~rx_active;
    assign tmr_zero  = (tmr_q == '0);
    assign tok_hit   = token_valid && (address == dev_addr) && (5'(end_point) < 5'(NUM_EP)) &&
                       (pid == PID_OUT || pid == PID_IN || pid == PID_SETUP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            ep_q          <= '0;
            tok_q         <= '0;
            resp_q        <= '0;
            data_seen_q   <= 1'b0;
            data1_q       <= 1'b0;
            err_seen_q    <= 1'b0;
            rx_active_q   <= 1'b0;
            toggle_q      <= '0;
            setup_seen_q  <= 1'b0;
            out_commit_q  <= 1'b0;
            out_discard_q <= 1'b0;
            in_commit_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            ep_q          <= ep_d;
            tok_q         <= tok_d;
            resp_q        <= resp_d;
            data_seen_q   <= data_seen_d;
            data1_q       <= data1_d;
            err_seen_q    <= err_seen_d;
            rx_active_q   <= rx_active;
            toggle_q      <= toggle_d;
            setup_seen_q  <= setup_seen_d;
            out_commit_q  <= out_commit_d;
            out_discard_q <= out_discard_d;
            in_commit_q   <= in_commit_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        ep_d          = ep_q;
        tok_d         = tok_q;
        resp_d        = resp_q;
        data_seen_d   = data_seen_q;
        data1_d       = data1_q;
        err_seen_d    = err_seen_q;
        toggle_d      = toggle_q;
        setup_seen_d  = 1'b0;
        out_commit_d  = 1'b0;
        out_discard_d = 1'b0;
        in_commit_d   = 1'b0;
        err_inc       = 1'b0;

        case (state_q)
            IDLE: ;
            GET_DATA: begin
                if (!data_seen_q) begin
                    if (pid_ok && (pid == PID_DATA0 || pid == PID_DATA1)) begin
                        data_seen_d = 1'b1;
                        data1_d     = pid[3];
                        err_seen_d  = 1'b0;
                    end else if (tmr_zero) begin
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end else begin
                    if (rx_error) err_seen_d = 1'b1;
                    if (rx_fall) begin
                        if (err_seen_q || rx_error || !crc16_ok) begin
                            out_discard_d = 1'b1;
                            err_inc       = 1'b1;
                            state_d       = IDLE;
                        end else if (tok_q == PID_SETUP) begin
                            // SETUP is answered even on a halted endpoint; DATA1 is malformed
                            if (data1_q) begin
                                out_discard_d = 1'b1;
                                state_d       = IDLE;
                            end else begin
                                resp_d         = PID_ACK;
                                toggle_d[ep_q] = 1'b1;
                                setup_seen_d   = 1'b1;
                                out_commit_d   = 1'b1;
                                state_d        = TURN;
                                tmr_d          = TURN_LOAD;
                            end
                        end else begin
                            state_d = TURN;
                            tmr_d   = TURN_LOAD;
                            if (stall_v[ep_q]) begin
                                resp_d        = PID_STALL;
                                out_discard_d = 1'b1;
                            end else if (!out_rdy_v[ep_q]) begin
                                resp_d        = PID_NAK;
                                out_discard_d = 1'b1;
                            end else if (data1_q != toggle_q[ep_q]) begin
                                resp_d        = PID_ACK;
                                out_discard_d = 1'b1;
                            end else begin
                                resp_d         = PID_ACK;
                                out_commit_d   = 1'b1;
                                toggle_d[ep_q] = ~toggle_q[ep_q];
                            end
                        end
                    end
                end
            end
            TURN: begin
                if (tmr_zero) state_d = SEND;
                else          tmr_d   = tmr_q - 1'b1;
            end
            SEND: begin
                if (tx_done) begin
                    if (resp_q == PID_DATA0 || resp_q == PID_DATA1) begin
                        state_d = WAIT_HS;
                        tmr_d   = TOUT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HS: begin
                if (pid_ok) begin
                    if (pid == PID_ACK) begin
                        in_commit_d    = 1'b1;
                        toggle_d[ep_q] = ~toggle_q[ep_q];
                    end
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // a token outside TURN/SEND silently cancels whatever was decided above
        if (token_valid && (state_q == IDLE || state_q == GET_DATA || state_q == WAIT_HS)) begin
            state_d       = IDLE;
            toggle_d      = toggle_q;
            setup_seen_d  = 1'b0;
            out_commit_d  = 1'b0;
            out_discard_d = 1'b0;
            in_commit_d   = 1'b0;
            err_inc       = 1'b0;
            if (tok_hit) begin
                ep_d        = end_point;
                tok_d       = pid;
                data_seen_d = 1'b0;
                err_seen_d  = 1'b0;
                if (pid == PID_IN) begin
                    state_d = TURN;
                    tmr_d   = TURN_LOAD;
                    if (stall_v[end_point])       resp_d = PID_STALL;
                    else if (!in_rdy_v[end_point]) resp_d = PID_NAK;
                    else if (toggle_q[end_point])  resp_d = PID_DATA1;
                    else                           resp_d = PID_DATA0;
                end else begin
                    state_d = GET_DATA;
                    tmr_d   = TOUT_LOAD;
                end
            end
        end
    end

    always_comb begin
        tx_req      = (state_q == SEND);
        tx_pid      = tx_req ? resp_q : 4'h0;
        ep_sel      = ep_q;
        setup_seen  = setup_seen_q;
        out_commit  = out_commit_q;
        out_discard = out_discard_q;
        in_commit   = in_commit_q;
    end

`ifdef USB_SEQ_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    logic err_inc_unused;
    assign err_inc_unused = err_inc;
`endif

endmodule

// File: tb/tb_usb_transaction_sequencer.sv
// Directed self-checking bench for usb_transaction_sequencer (default parameters).
`timescale 1ns/1ps

module tb_usb_transaction_sequencer;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_SETUP = 4'b1101;
    localparam logic [3:0] P_SOF   = 4'b0101;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_DATA1 = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [3:0] P_STALL = 4'b1110;
    localparam logic [6:0] DEV     = 7'h15;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] dev_addr;
    logic       rx_active, rx_error, pid_valid, token_valid, crc16_ok, tx_done;
    logic [3:0] pid, end_point;
    logic [6:0] address;
    logic [3:0] ep_stall, ep_out_rdy, ep_in_rdy;
    logic [3:0] tx_pid, ep_sel;
    logic       tx_req, setup_seen, out_commit, out_discard, in_commit;
`ifdef USB_SEQ_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int c_setup = 0, c_commit = 0, c_discard = 0, c_in = 0;
    int b_setup, b_commit, b_discard, b_in;

    always #5 clk = ~clk;

    usb_transaction_sequencer dut (
        .clk(clk), .reset(reset), .dev_addr(dev_addr),
        .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .pid_valid(pid_valid),
        .address(address), .end_point(end_point), .token_valid(token_valid),
        .crc16_ok(crc16_ok), .ep_stall(ep_stall), .ep_out_rdy(ep_out_rdy),
        .ep_in_rdy(ep_in_rdy), .tx_pid(tx_pid), .tx_req(tx_req), .tx_done(tx_done),
        .ep_sel(ep_sel), .setup_seen(setup_seen), .out_commit(out_commit),
        .out_discard(out_discard), .in_commit(in_commit)
`ifdef USB_SEQ_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always @(negedge clk) begin
        if (setup_seen)  c_setup++;
        if (out_commit)  c_commit++;
        if (out_discard) c_discard++;
        if (in_commit)   c_in++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_setup = c_setup; b_commit = c_commit; b_discard = c_discard; b_in = c_in;
    endtask

    task automatic chk_strobes(input string tag, input int s, input int c, input int d, input int i);
        chk({tag, "_setup"},   c_setup - b_setup, s);
        chk({tag, "_commit"},  c_commit - b_commit, c);
        chk({tag, "_discard"}, c_discard - b_discard, d);
        chk({tag, "_incommit"}, c_in - b_in, i);
    endtask

    task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        pid = p; address = a; end_point = e; token_valid = 1'b1;
        step();
        token_valid = 1'b0; pid = 4'h0;
    endtask

    task automatic send_data(input logic [3:0] d, input logic crc, input logic err);
        rx_active = 1'b1;
        step();
        pid = d; pid_valid = 1'b1;
        step();
        pid_valid = 1'b0; pid = 4'h0;
        repeat (4) step();
        crc16_ok = crc; rx_error = err; rx_active = 1'b0;
        step();
        crc16_ok = 1'b1; rx_error = 1'b0;
    endtask

    task automatic host_pid(input logic [3:0] p);
        pid = p; pid_valid = 1'b1;
        step();
        pid_valid = 1'b0; pid = 4'h0;
        step();
    endtask

    // exp < 0: no tx_req may appear; otherwise tx_req must rise 48 cycles after entry with exp
    task automatic expect_resp(input string tag, input int exp);
        int n = 0;
        while (!tx_req && n < 100) begin
            step();
            n++;
        end
        if (exp < 0) begin
            chk({tag, "_notx"}, tx_req, 0);
        end else begin
            chk({tag, "_turn"}, n, 48);
            chk({tag, "_pid"}, tx_pid, exp);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
    endtask

    task automatic xfer_out(input string tag, input logic [3:0] tok, input logic [3:0] ep,
                            input logic [3:0] d, input logic crc, input int exp,
                            input int s, input int c, input int dc);
        mark();
        send_token(tok, DEV, ep);
        send_data(d, crc, 1'b0);
        expect_resp(tag, exp);
        step();
        chk_strobes(tag, s, c, dc, 0);
    endtask

    task automatic xfer_in(input string tag, input logic [3:0] ep, input int exp);
        mark();
        send_token(P_IN, DEV, ep);
        expect_resp(tag, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; dev_addr = DEV;
        rx_active = 1'b0; rx_error = 1'b0; pid_valid = 1'b0; token_valid = 1'b0;
        crc16_ok = 1'b1; tx_done = 1'b0; pid = 4'h0; end_point = 4'h0; address = 7'h0;
        ep_stall = 4'h0; ep_out_rdy = 4'hF; ep_in_rdy = 4'hF;
        repeat (3) step();
        chk("rst_txreq", tx_req, 0);
        chk("rst_txpid", tx_pid, 0);
        chk("rst_epsel", ep_sel, 0);
        chk("rst_strb", {setup_seen, out_commit, out_discard, in_commit}, 0);
        reset = 1'b1;
        step();

        // SETUP and OUT toggle handling on ep2
        xfer_out("setup2", P_SETUP, 4'd2, P_DATA0, 1'b1, P_ACK, 1, 1, 0);
        chk("setup2_epsel", ep_sel, 2);
        xfer_out("out2_d1", P_OUT, 4'd2, P_DATA1, 1'b1, P_ACK, 0, 1, 0);
        xfer_out("out2_dup", P_OUT, 4'd2, P_DATA1, 1'b1, P_ACK, 0, 0, 1);
        xfer_out("out2_d0", P_OUT, 4'd2, P_DATA0, 1'b1, P_ACK, 0, 1, 0);

        // IN toggle handling and handshake timeout on ep1
        xfer_in("in1_a", 4'd1, P_DATA0);
        host_pid(P_ACK);
        chk("in1_a_commit", c_in - b_in, 1);
        xfer_in("in1_b", 4'd1, P_DATA1);
        repeat (300) step();
        host_pid(P_ACK);
        chk("in1_b_timeout", c_in - b_in, 0);
        xfer_in("in1_c", 4'd1, P_DATA1);
        repeat (286) step();
        host_pid(P_ACK);
        chk("in1_c_late_ack", c_in - b_in, 1);
        xfer_in("in1_d", 4'd1, P_DATA0);
        repeat (288) step();
        host_pid(P_ACK);
        chk("in1_d_expired", c_in - b_in, 0);
        xfer_in("in1_e", 4'd1, P_DATA0);
        host_pid(P_ACK);
        chk("in1_e_commit", c_in - b_in, 1);

        // stall / NAK / ignored tokens
        ep_stall = 4'b1000;
        xfer_in("in3_stall", 4'd3, P_STALL);
        host_pid(P_ACK);
        chk("in3_nocommit", c_in - b_in, 0);
        ep_stall = 4'h0;
        ep_in_rdy = 4'b1101;
        xfer_in("in1_nak", 4'd1, P_NAK);
        ep_in_rdy = 4'hF;
        mark();
        send_token(P_IN, 7'h3a, 4'd1);
        expect_resp("wrong_addr", -1);
        send_token(P_IN, DEV, 4'd4);
        expect_resp("ep4", -1);
        send_token(P_SOF, DEV, 4'd0);
        expect_resp("sof_tok", -1);
        send_token(P_OUT, DEV, 4'd4);
        send_data(P_DATA0, 1'b1, 1'b0);
        expect_resp("out_ep4", -1);
        chk_strobes("ignored", 0, 0, 0, 0);

        // OUT error cases on ep0
        xfer_out("out0_badcrc", P_OUT, 4'd0, P_DATA0, 1'b0, -1, 0, 0, 1);
`ifdef USB_SEQ_ERRCNT_EN
        chk("errcnt_crc", err_count, 3);
`endif
        xfer_out("out0_good", P_OUT, 4'd0, P_DATA0, 1'b1, P_ACK, 0, 1, 0);
        ep_out_rdy = 4'b1110;
        xfer_out("out0_nak", P_OUT, 4'd0, P_DATA1, 1'b1, P_NAK, 0, 0, 1);
        ep_out_rdy = 4'hF;
        ep_stall = 4'b0001;
        xfer_out("out0_stall", P_OUT, 4'd0, P_DATA1, 1'b1, P_STALL, 0, 0, 1);
        xfer_out("setup0_stalled", P_SETUP, 4'd0, P_DATA0, 1'b1, P_ACK, 1, 1, 0);
        ep_stall = 4'h0;
        xfer_out("setup0_d1", P_SETUP, 4'd0, P_DATA1, 1'b1, -1, 0, 0, 1);
        mark();
        send_token(P_OUT, DEV, 4'd0);
        repeat (300) step();
        send_data(P_DATA1, 1'b1, 1'b0);
        expect_resp("getdata_tmo", -1);
        chk_strobes("getdata_tmo", 0, 0, 0, 0);

        // synchronous reset during TURN
        mark();
        send_token(P_IN, DEV, 4'd1);
        repeat (10) step();
        reset = 1'b0;
        step();
        chk("rstturn_txreq", tx_req, 0);
        chk("rstturn_epsel", ep_sel, 0);
        reset = 1'b1;
        repeat (60) step();
        chk("rstturn_idle", tx_req, 0);
        chk_strobes("rstturn", 0, 0, 0, 0);
        xfer_in("in1_after_rst", 4'd1, P_DATA0);
        host_pid(P_ACK);
        xfer_out("out2_after_rst", P_OUT, 4'd2, P_DATA0, 1'b1, P_ACK, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
